// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
//
// Issue/writeback stage wrapped around an external 4-bit combinational ALU.
// Each instruction walks IDLE -> EXEC -> WB (three cycles):
//   IDLE : accept on instr_valid, read operands from the register file and
//          register them onto the ALU inputs.
//   EXEC : ALU inputs held stable; the ALU result is captured at the edge.
//   WB   : result written to rf[rd], carry/zero flags updated, one-cycle
//          result_valid pulse presented the following cycle.
//
// Ports
//   clk, rst          : clock (rising edge), synchronous active-high reset
//   instr_valid/ready : instruction handshake (ready is a pure function of state)
//   instr_op          : ALU select forwarded to alu_sel
//   instr_rd/rs1/rs2  : destination / source register indices
//   instr_imm_en/imm  : optional immediate replacing rf[rs2] as operand B
//   alu_a/b/sel       : registered operands and select to the external ALU
//   alu_y             : DW+1 bit ALU result (MSB is carry/borrow)
//   result_valid/data/rd : writeback report (data/rd hold until next writeback)
//   flag_c, flag_z    : persistent carry and zero flags
//   dbg_addr/dbg_data : combinational read port of the register file
// ---------------------------------------------------------------------------
module alu_op_sequencer #(
    parameter int RF_DEPTH = 4,
    parameter int DW       = 4,
    localparam int AW      = $clog2(RF_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [2:0]    instr_op,
    input  logic [AW-1:0] instr_rd,
    input  logic [AW-1:0] instr_rs1,
    input  logic [AW-1:0] instr_rs2,
    input  logic          instr_imm_en,
    input  logic [DW-1:0] instr_imm,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [2:0]    alu_sel,
    input  logic [DW:0]   alu_y,
    output logic          result_valid,
    output logic [DW-1:0] result_data,
    output logic [AW-1:0] result_rd,
    output logic          flag_c,
    output logic          flag_z,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t        state_reg;
    state_t        state_next;

    // Decoded per-state strobes
    logic          accept;
    logic          capture;
    logic          writeback;

    // Register file and pipeline registers
    logic [DW-1:0] rf_reg [RF_DEPTH];
    logic [DW-1:0] alu_a_reg;
    logic [DW-1:0] alu_b_reg;
    logic [2:0]    alu_sel_reg;
    logic [AW-1:0] rd_reg;
    logic [DW:0]   y_reg;
    logic          result_valid_reg;
    logic [DW-1:0] result_data_reg;
    logic [AW-1:0] result_rd_reg;
    logic          flag_c_reg;
    logic          flag_z_reg;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (instr_valid) state_next = EXEC;
            EXEC:    state_next = WB;
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output decode. instr_ready depends on state only, so there is
    // no combinational path from instr_valid back to instr_ready.
    // ------------------------------------------------------------------
    always_comb begin
        instr_ready = 1'b0;
        accept      = 1'b0;
        capture     = 1'b0;
        writeback   = 1'b0;
        case (state_reg)
            IDLE: begin
                instr_ready = 1'b1;
                accept      = instr_valid;
            end
            EXEC:    capture   = 1'b1;
            WB:      writeback = 1'b1;
            default: instr_ready = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Operand issue, result capture and writeback reporting.
    // Operands are read straight from the register file at accept: issue is
    // serial, so any earlier writeback has already landed and no bypass is
    // needed even when rs1/rs2 match the previous rd.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a_reg        <= '0;
            alu_b_reg        <= '0;
            alu_sel_reg      <= '0;
            rd_reg           <= '0;
            y_reg            <= '0;
            result_valid_reg <= 1'b0;
            result_data_reg  <= '0;
            result_rd_reg    <= '0;
            flag_c_reg       <= 1'b0;
            flag_z_reg       <= 1'b0;
        end else begin
            if (accept) begin
                alu_a_reg   <= rf_reg[instr_rs1];
                alu_b_reg   <= instr_imm_en ? instr_imm : rf_reg[instr_rs2];
                alu_sel_reg <= instr_op;
                rd_reg      <= instr_rd;
            end

            if (capture) begin
                y_reg <= alu_y;
            end

            // Single-cycle pulse: only the WB state raises it.
            result_valid_reg <= writeback;

            if (writeback) begin
                result_data_reg <= y_reg[DW-1:0];
                result_rd_reg   <= rd_reg;
                flag_c_reg      <= y_reg[DW];
                flag_z_reg      <= (y_reg[DW-1:0] == '0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Register file: one register per entry so that reset can clear every
    // word in a single cycle. Only the WB state writes.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < RF_DEPTH; gi++) begin : g_rf
            always_ff @(posedge clk) begin
                if (rst) begin
                    rf_reg[gi] <= '0;
                end else if (writeback && (rd_reg == AW'(gi))) begin
                    rf_reg[gi] <= y_reg[DW-1:0];
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign alu_a        = alu_a_reg;
    assign alu_b        = alu_b_reg;
    assign alu_sel      = alu_sel_reg;
    assign result_valid = result_valid_reg;
    assign result_data  = result_data_reg;
    assign result_rd    = result_rd_reg;
    assign flag_c       = flag_c_reg;
    assign flag_z       = flag_z_reg;
    assign dbg_data     = rf_reg[dbg_addr];

endmodule
